// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: cart and USB share one memory controller command
// port. Cart has priority, but USB is guaranteed a grant after STARVE_LIMIT
// consecutive cart grants while it waits. Reads block further grants until
// data returns or the read times out.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no read outstanding; a grant may be issued this edge
// WAIT_RD | read command issued; waiting for mem_rd_valid or timeout
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RD_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cart_rd,
  input  logic        cart_wr,
  input  logic [25:0] cart_addr,
  input  logic [1:0]  cart_width,
  input  logic [31:0] cart_wr_data,
  output logic        cart_acc,
  output logic        cart_rd_valid,
  output logic [31:0] cart_rd_data,

  input  logic        usb_rd,
  input  logic        usb_wr,
  input  logic [25:0] usb_addr,
  input  logic [1:0]  usb_width,
  input  logic [31:0] usb_wr_data,
  output logic        usb_acc,
  output logic        usb_rd_valid,
  output logic [31:0] usb_rd_data,

  input  logic        mem_rd_ready,
  input  logic        mem_wr_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [25:0] mem_addr,
  output logic [1:0]  mem_data_width,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,

  output logic        busy,
  output logic        timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] rd_timer;
  logic          owner_usb;

  logic          cart_wr_elig;
  logic          cart_rd_elig;
  logic          cart_elig;
  logic          usb_wr_elig;
  logic          usb_rd_elig;
  logic          usb_elig;
  logic          grant_open;
  logic          usb_forced;
  logic          grant_cart;
  logic          grant_usb;
  logic          sel_wr;
  logic [25:0]   sel_addr;
  logic [1:0]    sel_width;
  logic [31:0]   sel_wr_data;
  logic [SW-1:0] starve_next;
  logic          rd_done;
  logic [31:0]   ret_data;

  // Eligibility, priority resolution and winner field selection.
  // A write command pulse last cycle means the requester has not yet seen
  // its acc, so its request is still up; no grant on that edge.
  always_comb begin
    cart_wr_elig = cart_wr & mem_wr_ready;
    cart_rd_elig = cart_rd & ~cart_wr & mem_rd_ready;
    cart_elig    = cart_wr_elig | cart_rd_elig;
    usb_wr_elig  = usb_wr & mem_wr_ready;
    usb_rd_elig  = usb_rd & ~usb_wr & mem_rd_ready;
    usb_elig     = usb_wr_elig | usb_rd_elig;

    grant_open   = (state == IDLE) & ~mem_wr & ~mem_rd;
    usb_forced   = (starve_cnt == STARVE_MAX) & usb_elig;
    grant_cart   = grant_open & cart_elig & ~usb_forced;
    grant_usb    = grant_open & usb_elig & (~cart_elig | usb_forced);

    sel_wr       = grant_usb ? usb_wr       : cart_wr;
    sel_addr     = grant_usb ? usb_addr     : cart_addr;
    sel_width    = grant_usb ? usb_width    : cart_width;
    sel_wr_data  = grant_usb ? usb_wr_data  : cart_wr_data;

    starve_next  = starve_cnt;
    if (grant_usb) begin
      starve_next = '0;
    end else if (grant_cart) begin
      if (usb_rd | usb_wr) begin
        starve_next = (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 1'b1;
      end else begin
        starve_next = '0;
      end
    end

    // Valid data wins over a simultaneous timeout expiry.
    rd_done  = mem_rd_valid | (rd_timer == '0);
    ret_data = mem_rd_valid ? mem_rd_data : 32'hFFFF_FFFF;
  end

  // Arbiter FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      rd_timer       <= '0;
      owner_usb      <= 1'b0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= '0;
      mem_data_width <= '0;
      mem_wr_data    <= '0;
      cart_acc       <= 1'b0;
      usb_acc        <= 1'b0;
      cart_rd_valid  <= 1'b0;
      usb_rd_valid   <= 1'b0;
      cart_rd_data   <= '0;
      usb_rd_data    <= '0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      cart_acc      <= 1'b0;
      usb_acc       <= 1'b0;
      cart_rd_valid <= 1'b0;
      usb_rd_valid  <= 1'b0;
      timeout_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_cart | grant_usb) begin
            mem_addr       <= sel_addr;
            mem_data_width <= sel_width;
            mem_wr_data    <= sel_wr_data;
            mem_wr         <= sel_wr;
            mem_rd         <= ~sel_wr;
            cart_acc       <= grant_cart;
            usb_acc        <= grant_usb;
            starve_cnt     <= starve_next;
            if (!sel_wr) begin
              state     <= WAIT_RD;
              busy      <= 1'b1;
              owner_usb <= grant_usb;
              rd_timer  <= TIMER_LOAD;
            end
          end
        end

        WAIT_RD: begin
          if (rd_done) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= ~mem_rd_valid;
            if (owner_usb) begin
              usb_rd_valid <= 1'b1;
              usb_rd_data  <= ret_data;
            end else begin
              cart_rd_valid <= 1'b1;
              cart_rd_data  <= ret_data;
            end
          end else begin
            rd_timer <= rd_timer - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, 4, consecutive cart grants allowed while USB waits.
REQ-002 SHALL have parameter RD_TIMEOUT, 1024, cycles a read may wait for mem_rd_valid.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have ports cart_rd / cart_wr  in  1  cart read / write request, held until cart_acc.
REQ-006 SHALL have ports cart_addr  in  26, cart_width  in  2, cart_wr_data  in  32: cart request fields.
REQ-007 SHALL have ports cart_acc  out  1, cart_rd_valid  out  1, cart_rd_data  out  32: cart accept pulse, read return.
REQ-008 SHALL have ports usb_rd / usb_wr / usb_addr / usb_width / usb_wr_data / usb_acc / usb_rd_valid / usb_rd_data with the same directions, widths and meaning for USB.
REQ-009 SHALL have ports mem_rd_ready / mem_wr_ready  in  1  controller can take a read / write.
REQ-010 SHALL have ports mem_rd / mem_wr  out  1  one-cycle command pulses.
REQ-011 SHALL have ports mem_addr  out  26, mem_data_width  out  2, mem_wr_data  out  32: command fields.
REQ-012 SHALL have ports mem_rd_data  in  32, mem_rd_valid  in  1: read return.
REQ-013 SHALL have ports busy  out  1 (state not IDLE) and timeout_err  out  1 (one-cycle pulse).

Function
REQ-014 SHALL implement states IDLE, WAIT_RD; all outputs registered.
REQ-015 In IDLE, a requester is eligible for write when its wr is high and mem_wr_ready high, for read when rd high (wr low) and mem_rd_ready high.
REQ-016 A requester asserting rd and wr together SHALL be treated as a write only.
REQ-017 Priority: cart over USB, except when starve count equals STARVE_LIMIT and USB eligible -> USB wins.
REQ-018 Starve count (width clog2(STARVE_LIMIT+1)): +1 on cart grant while USB has rd or wr high; cleared on USB grant or on cart grant with USB idle; saturates at STARVE_LIMIT.
REQ-019 Grant at edge N: cycle N+1 has exactly one of mem_rd/mem_wr high for one cycle, winner's acc high for one cycle, mem_addr/mem_data_width/mem_wr_data loaded from winner.
REQ-020 mem_addr, mem_data_width, mem_wr_data SHALL hold until the next grant.
REQ-021 Write grant: state stays IDLE; next grant possible no earlier than edge N+2 (acc not seen by requester until N+1).
REQ-022 Read grant: state -> WAIT_RD, owner recorded; no further grants until return to IDLE.
REQ-023 WAIT_RD: mem_rd_valid sampled high at edge M -> cycle M+1 owner's rd_valid high one cycle, rd_data = sampled mem_rd_data; state -> IDLE.
REQ-024 Non-owner rd_valid SHALL stay low; rd_data of each port holds its last value.
REQ-025 WAIT_RD timeout: after RD_TIMEOUT cycles without mem_rd_valid -> owner rd_valid pulse with rd_data 32'hFFFF_FFFF, timeout_err pulse same cycle, state -> IDLE.
REQ-026 mem_rd_valid in IDLE SHALL be ignored (no rd_valid, no state change).
REQ-027 mem_rd_valid coinciding with timeout expiry SHALL be treated as valid data, no timeout_err.
REQ-028 No grant when neither requester eligible; acc never asserted without a matching mem command pulse.

Reset
REQ-029 On rst: state IDLE, starve count 0, mem_rd/mem_wr/cart_acc/usb_acc/cart_rd_valid/usb_rd_valid/timeout_err 0, mem_addr 0, mem_data_width 0, mem_wr_data 0, rd_data ports 0, busy 0.
REQ-030 rst during WAIT_RD SHALL abandon the read; a later mem_rd_valid produces no rd_valid.

Verification
REQ-031 Cart write addr 0x0000010, data 0x0123ABCD, width 2'b11, readies high -> next cycle mem_wr=1, mem_addr 0x10, mem_wr_data 0x0123ABCD, cart_acc=1, one cycle.
REQ-032 Cart read addr 0x10, controller returns valid 0x0123ABCD 5 cycles later -> cart_rd_valid one cycle after, cart_rd_data 0x0123ABCD, usb_rd_valid stays 0.
REQ-033 Cart and USB writes held continuously, STARVE_LIMIT 4 -> grant order C,C,C,C,U,C,C,C,C,U.
REQ-034 USB read, mem_rd_valid never returned, RD_TIMEOUT 16 -> after 16 cycles usb_rd_valid=1, usb_rd_data 0xFFFFFFFF, timeout_err=1, busy drops.
REQ-035 rst asserted in WAIT_RD, mem_rd_valid 3 cycles after release -> no rd_valid, busy 0, all outputs at reset values.
REQ-036 Cart write held, mem_wr_ready low 10 cycles -> no mem_wr/cart_acc until ready rises, then one grant.
